// File: rtl/intersection_pkg.sv
// Shared definitions for the two-road intersection controller.
// Holds the 3-bit phase codes driven by phase_sequencer and consumed by
// led_control, the road index constants used to address per-road vectors,
// and a small helper that classifies the all-red clearance phases.
package intersection_pkg;

  // Phase codes, in the order the normal cycle visits them.
  typedef enum logic [2:0] {
    PH_NS_GREEN     = 3'd0,
    PH_NS_YELLOW    = 3'd1,
    PH_ALLRED_NS_EW = 3'd2,
    PH_EW_LEFT      = 3'd3,
    PH_EW_GREEN     = 3'd4,
    PH_EW_YELLOW    = 3'd5,
    PH_ALLRED_EW_NS = 3'd6,
    PH_NS_LEFT      = 3'd7
  } phase_e;

  // Road indices into per-road vectors such as left_req.
  localparam bit [0:0] NS = 1'b0;
  localparam bit [0:0] EW = 1'b1;

  // True for both all-red clearance phases.
  function automatic logic is_allred(input phase_e p);
    return (p == PH_ALLRED_NS_EW) || (p == PH_ALLRED_EW_NS);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   CLOCK_50 - system clock
//   reset    - asynchronous, active-high reset
//   tick     - registered pulse, high in the cycle the count equals TICK_DIV-1
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(TICK_DIV - 1);
  // tick is registered, so it is raised one count early to land on LAST_CNT.
  localparam logic [DIV_W-1:0] PRE_LAST_CNT = DIV_W'(TICK_DIV - 2);

  logic [DIV_W-1:0] count_r;
  logic             tick_r;

  // Count 0..TICK_DIV-1 with wrap and register the tick decode.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      if (count_r == LAST_CNT) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + DIV_W'(1);
      end
      tick_r <= (count_r == PRE_LAST_CNT);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/phase_sequencer.sv
// Timing/sequencing FSM for the two-road intersection.
// Steps through the eight phase codes on prescaled ticks with per-phase
// durations, skips protected lefts that have no latched demand, and handles
// emergency preemption by forcing the signal heads to an all-red hold.
// Ports:
//   CLOCK_50         - system clock
//   reset            - asynchronous, active-high reset
//   left_req[1:0]    - left-turn demand (bit0 NS, bit1 EW), level or pulse
//   emergency        - preemption request, synchronous to CLOCK_50
//   phase[2:0]       - current phase code (registered)
//   phase_start      - one-cycle pulse in the first cycle of each phase
//   ticks_left       - remaining ticks in the current phase minus 1
//   tick             - one-cycle prescaler pulse
//   emergency_active - high while preemption is in effect
module phase_sequencer
  import intersection_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned LEFT_TICKS   = 5,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [1:0]       left_req,
  input  logic             emergency,
  output logic [2:0]       phase,
  output logic             phase_start,
  output logic [CNT_W-1:0] ticks_left,
  output logic             tick,
  output logic             emergency_active
);

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] LEFT_LOAD   = CNT_W'(LEFT_TICKS - 1);

  phase_e           phase_r;
  phase_e           phase_nxt_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic             change_s;
  logic             start_r;
  logic             first_r;
  logic [1:0]       latch_r;
  logic [1:0]       latch_nxt_s;
  logic             emer_r;
  logic             hold_r;
  logic             hold_nxt_s;
  logic             active_r;
  logic             active_nxt_s;
  logic             tick_s;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick_s)
  );

  // Timer value loaded on entry: phase duration minus one.
  function automatic logic [CNT_W-1:0] reload_value(input phase_e p);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:         return GREEN_LOAD;
      PH_NS_YELLOW, PH_EW_YELLOW:       return YELLOW_LOAD;
      PH_ALLRED_NS_EW, PH_ALLRED_EW_NS: return ALLRED_LOAD;
      PH_EW_LEFT, PH_NS_LEFT:           return LEFT_LOAD;
      default:                          return ALLRED_LOAD;
    endcase
  endfunction

  // Normal-cycle successor; the all-red phases decide whether to serve a left.
  function automatic phase_e normal_successor(input phase_e p, input logic [1:0] lat);
    case (p)
      PH_NS_GREEN:     return PH_NS_YELLOW;
      PH_NS_YELLOW:    return PH_ALLRED_NS_EW;
      PH_ALLRED_NS_EW: return lat[EW] ? PH_EW_LEFT : PH_EW_GREEN;
      PH_EW_LEFT:      return PH_EW_GREEN;
      PH_EW_GREEN:     return PH_EW_YELLOW;
      PH_EW_YELLOW:    return PH_ALLRED_EW_NS;
      PH_ALLRED_EW_NS: return lat[NS] ? PH_NS_LEFT : PH_NS_GREEN;
      PH_NS_LEFT:      return PH_NS_GREEN;
      default:         return PH_ALLRED_EW_NS;
    endcase
  endfunction

  // Phases that an emergency cuts short: greens go to yellow, arrows drop to all-red.
  function automatic logic preemptible(input phase_e p);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN, PH_EW_LEFT, PH_NS_LEFT: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Where an emergency sends a preemptible phase.
  function automatic phase_e preempt_target(input phase_e p);
    case (p)
      PH_NS_GREEN: return PH_NS_YELLOW;
      PH_EW_GREEN: return PH_EW_YELLOW;
      PH_EW_LEFT:  return PH_ALLRED_EW_NS;
      PH_NS_LEFT:  return PH_ALLRED_NS_EW;
      default:     return PH_ALLRED_EW_NS;
    endcase
  endfunction

  // Next phase and timer: all-red hold first, then emergency, then expiry, then countdown.
  always_comb begin
    phase_nxt_s = phase_r;
    timer_nxt_s = timer_r;
    change_s    = 1'b0;
    if (is_allred(phase_r) && emer_r) begin
      // Keep the clearance timer full so release always gets a complete all-red.
      timer_nxt_s = ALLRED_LOAD;
    end else if (tick_s && emer_r && preemptible(phase_r)) begin
      change_s    = 1'b1;
      phase_nxt_s = preempt_target(phase_r);
      timer_nxt_s = reload_value(preempt_target(phase_r));
    end else if (tick_s && (timer_r == '0)) begin
      change_s    = 1'b1;
      phase_nxt_s = normal_successor(phase_r, latch_r);
      timer_nxt_s = reload_value(normal_successor(phase_r, latch_r));
    end else if (tick_s) begin
      timer_nxt_s = timer_r - CNT_W'(1);
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // Left-turn latches: cleared on entry to their arrow, new demand always wins.
  always_comb begin
    latch_nxt_s = latch_r;
    if (change_s && (phase_nxt_s == PH_EW_LEFT)) begin
      latch_nxt_s[EW] = 1'b0;
    end else begin
      latch_nxt_s[EW] = latch_r[EW];
    end
    if (change_s && (phase_nxt_s == PH_NS_LEFT)) begin
      latch_nxt_s[NS] = 1'b0;
    end else begin
      latch_nxt_s[NS] = latch_r[NS];
    end
    latch_nxt_s = latch_nxt_s | left_req;
  end

  // Preemption hold tracking: sticks through the clearance and drops on leaving all-red.
  always_comb begin
    hold_nxt_s   = is_allred(phase_nxt_s) && (emer_r || (hold_r && !change_s));
    active_nxt_s = emergency || hold_nxt_s;
  end

  // State register for phase, timer, latches and preemption flags.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      phase_r  <= PH_ALLRED_EW_NS;
      timer_r  <= ALLRED_LOAD;
      start_r  <= 1'b0;
      first_r  <= 1'b1;
      latch_r  <= 2'b00;
      emer_r   <= 1'b0;
      hold_r   <= 1'b0;
      active_r <= 1'b0;
    end else begin
      phase_r  <= phase_nxt_s;
      timer_r  <= timer_nxt_s;
      // first_r marks the restart after reset as a phase start as well.
      start_r  <= change_s || first_r;
      first_r  <= 1'b0;
      latch_r  <= latch_nxt_s;
      emer_r   <= emergency;
      hold_r   <= hold_nxt_s;
      active_r <= active_nxt_s;
    end
  end

  assign phase            = phase_r;
  assign phase_start      = start_r;
  assign ticks_left       = timer_r;
  assign tick             = tick_s;
  assign emergency_active = active_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with hand-computed timings
// and a randomized demand/emergency run.
module tb_phase_sequencer;

  localparam int TICK_DIV = 4;
  localparam int GREEN    = 3;
  localparam int YELLOW   = 2;
  localparam int ALLRED   = 1;
  localparam int LEFT     = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       left_req = 2'b00;
  logic             emergency = 1'b0;
  logic [2:0]       phase;
  logic             phase_start;
  logic [CNT_W-1:0] ticks_left;
  logic             tick;
  logic             emergency_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer #(
    .TICK_DIV     (TICK_DIV),
    .GREEN_TICKS  (GREEN),
    .YELLOW_TICKS (YELLOW),
    .ALLRED_TICKS (ALLRED),
    .LEFT_TICKS   (LEFT),
    .CNT_W        (CNT_W)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (rst),
    .left_req         (left_req),
    .emergency        (emergency),
    .phase            (phase),
    .phase_start      (phase_start),
    .ticks_left       (ticks_left),
    .tick             (tick),
    .emergency_active (emergency_active)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_cnt, m_phase, m_timer;
  bit     m_start, m_first, m_emr, m_hold, m_act;
  bit [1:0] m_lat;
  int     dur [8] = '{GREEN, YELLOW, ALLRED, LEFT, GREEN, YELLOW, ALLRED, LEFT};

  function automatic int succ(input int p, input bit [1:0] lat);
    case (p)
      2:       return lat[1] ? 3 : 4;
      6:       return lat[0] ? 7 : 0;
      7:       return 0;
      default: return p + 1;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 6; m_timer = ALLRED - 1;
    m_start = 0; m_first = 1; m_emr = 0; m_hold = 0; m_act = 0; m_lat = 2'b00;
  endtask

  task automatic model_step();
    bit t;
    bit chg;
    int nxt;
    t = (m_cnt == TICK_DIV - 1);
    m_cnt = (m_cnt + 1) % TICK_DIV;
    nxt = m_phase;
    chg = 0;
    if ((m_phase == 2 || m_phase == 6) && m_emr) begin
      m_timer = ALLRED - 1;
    end else if (t) begin
      if (m_emr && (m_phase == 0 || m_phase == 4)) nxt = m_phase + 1;
      else if (m_emr && m_phase == 3) nxt = 6;
      else if (m_emr && m_phase == 7) nxt = 2;
      else if (m_timer == 0) nxt = succ(m_phase, m_lat);
      else m_timer = m_timer - 1;
      chg = (nxt != m_phase);
    end
    if (chg) m_timer = dur[nxt] - 1;
    if (chg && nxt == 3) m_lat[1] = 1'b0;
    if (chg && nxt == 7) m_lat[0] = 1'b0;
    m_lat = m_lat | left_req;
    m_hold = (nxt == 2 || nxt == 6) && (m_emr || (m_hold && !chg));
    m_emr = emergency;
    m_act = emergency || m_hold;
    m_start = chg || m_first;
    m_first = 0;
    m_phase = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("phase", phase, m_phase);
        check("ticks_left", ticks_left, m_timer);
        check("phase_start", phase_start, m_start);
        check("tick", tick, (m_cnt == TICK_DIV - 1));
        check("emergency_active", emergency_active, m_act);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; left_req = 2'b00; emergency = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (phase != p && n < budget);
    check("reach_phase", phase, p);
  endtask

  task automatic wait_change(input int budget, output int np, output int n);
    int p0;
    p0 = phase;
    n = 0;
    do begin @(negedge clk); n++; end while (phase == p0 && n < budget);
    np = phase;
    check("phase_change_seen", (phase != p0), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, np, prev, starts, last_tick, dwell0;
    int seq[$];
    int exp_seq [8] = '{6, 0, 1, 2, 4, 5, 6, 0};

    // 1: reset values, free-running sequence, dwell, tick period
    repeat (2) @(negedge clk);
    check("reset_phase", phase, 6);
    check("reset_ticks_left", ticks_left, 0);
    check("reset_phase_start", phase_start, 0);
    check("reset_tick", tick, 0);
    check("reset_emergency_active", emergency_active, 0);
    rst = 1'b0;
    prev = -1; starts = 0; last_tick = -1; dwell0 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (phase != prev) begin seq.push_back(phase); prev = phase; end
      if (phase_start) starts++;
      if (c == 1) check("start_after_release", phase_start, 1);
      if (c == 4) check("first_phase_0", phase, 0);
      if (phase == 0 && c <= 40) dwell0++;
      if (tick) begin
        if (last_tick >= 0) check("tick_period", c - last_tick, 4);
        last_tick = c;
      end
    end
    check("seq_len", seq.size(), 11);
    for (int i = 0; i < 8; i++)
      check("seq_entry", (seq.size() > i) ? seq[i] : -1, exp_seq[i]);
    check("dwell_phase0", dwell0, 12);
    check("phase_start_count", starts, 11);

    // 2: EW left served once, then skipped
    do_reset();
    wait_phase(0, 20, n);
    left_req = 2'b10; @(negedge clk); left_req = 2'b00;
    wait_phase(2, 40, n);
    wait_change(10, np, n);  check("ew_left_entered", np, 3);
    wait_change(20, np, n);  check("ew_left_next", np, 4); check("ew_left_dwell", n, 8);
    wait_phase(2, 100, n);
    wait_change(10, np, n);  check("ew_left_skipped", np, 4);

    // 3: NS left served on two consecutive passes
    do_reset();
    wait_phase(4, 40, n);
    left_req = 2'b01; @(negedge clk); left_req = 2'b00;
    wait_phase(6, 40, n);
    wait_change(10, np, n);  check("ns_left_first", np, 7);
    left_req = 2'b01; @(negedge clk); left_req = 2'b00;
    wait_change(20, np, n);  check("ns_left_exit", np, 0);
    wait_phase(6, 100, n);
    wait_change(10, np, n);  check("ns_left_second", np, 7);

    // 4: emergency in NS green, hold in all-red, release
    do_reset();
    wait_phase(0, 20, n);
    check("t4_timer_at_entry", ticks_left, 2);
    emergency = 1'b1;
    @(negedge clk);
    check("t4_active_registered", emergency_active, 1);
    wait_change(20, np, n);  check("t4_to_yellow", np, 1); check("t4_preempt_latency", n, 3);
    wait_change(20, np, n);  check("t4_to_allred", np, 2); check("t4_yellow_full", n, 8);
    repeat (20) @(negedge clk);
    check("t4_hold_phase", phase, 2);
    check("t4_hold_ticks_left", ticks_left, 0);
    check("t4_hold_active", emergency_active, 1);
    emergency = 1'b0;
    wait_change(20, np, n);  check("t4_release_to", np, 4); check("t4_release_latency", n, 4);
    check("t4_active_dropped", emergency_active, 0);

    // 5: emergency in EW left drops to all-red; emergency in yellow completes it
    do_reset();
    wait_phase(0, 20, n);
    left_req = 2'b10; @(negedge clk); left_req = 2'b00;
    wait_phase(3, 60, n);
    emergency = 1'b1;
    wait_change(20, np, n);  check("t5_left_to_allred", np, 6); check("t5_left_latency", n, 4);
    repeat (12) @(negedge clk);
    check("t5_hold6", phase, 6);
    emergency = 1'b0;
    wait_change(20, np, n);  check("t5_release_to", np, 0);
    wait_phase(5, 100, n);
    emergency = 1'b1;
    wait_change(20, np, n);  check("t5_yellow_to", np, 6); check("t5_yellow_full", n, 8);
    repeat (8) @(negedge clk);
    check("t5_hold6_b", phase, 6);
    emergency = 1'b0;
    wait_change(20, np, n);  check("t5_release_b", np, 0);

    // 6: asynchronous reset mid-phase 4 clears latches immediately
    do_reset();
    wait_phase(4, 40, n);
    left_req = 2'b01; @(negedge clk); left_req = 2'b00;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_phase", phase, 6);
    check("t6_async_ticks_left", ticks_left, 0);
    check("t6_async_phase_start", phase_start, 0);
    check("t6_async_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_change(20, np, n);  check("t6_restart_to", np, 0); check("t6_restart_latency", n, 4);

    // 7: randomized demand and emergency against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      left_req = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 79) == 0) emergency = ~emergency;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    left_req = 2'b00;
    emergency = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised timing/sequencing FSM for the two-road intersection.
- Generates the 3-bit phase code consumed by led_control (0 NS green, 1 NS yellow, 2 all-red, 3 EW left, 4 EW green, 5 EW yellow, 6 all-red, 7 NS left).
- Replaces the fixed 10 s counter chain and manual switch selection with:
  - a prescaled tick;
  - per-phase durations;
  - demand-driven left-turn skipping;
  - emergency preemption.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per tick (1 s at 50 MHz); must be >= 2.
- GREEN_TICKS, 10: green duration in ticks; must be >= 1.
- YELLOW_TICKS, 3: yellow duration in ticks; must be >= 1.
- ALLRED_TICKS, 1: all-red clearance in ticks; must be >= 1.
- LEFT_TICKS, 5: protected-left duration in ticks; must be >= 1.
- CNT_W, 8: phase timer width; must hold max(*_TICKS)-1.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- left_req  in  2  left-turn demand; bit0 = NS, bit1 = EW; level or pulse.
- emergency  in  1  preemption request, synchronous to CLOCK_50.
- phase  out  3  current phase code, registered.
- phase_start  out  1  one-cycle pulse in the first cycle of each new phase.
- ticks_left  out  CNT_W  remaining ticks in the current phase minus 1.
- tick  out  1  one-cycle prescaler pulse.
- emergency_active  out  1  high while preemption is in effect.

Behaviour:
- Clock and reset:
  - One clock, CLOCK_50.
  - reset is asynchronous and active-high.
  - All state clears immediately when reset asserts, independent of the clock.
- Reset values:
  - phase=6, ticks_left=ALLRED_TICKS-1.
  - Prescaler=0, tick=0, phase_start=0.
  - Left latches=00, emergency_active=0.
  - First transition after reset goes to phase 0, or to 7 if NS left is latched.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - Free-running; never reset by phase changes.
- Phase timer:
  - On phase entry, loaded with duration-1.
  - Decrements by 1 on each tick while nonzero.
  - A phase ends on a tick with timer==0.
  - phase, ticks_left and phase_start all update on the clock edge after that tick cycle (latency 1).
- Normal sequence:
  - 0 -> 1 -> 2 -> (3 if EW latch else 4) -> 4 -> 5 -> 6 -> (7 if NS latch else 0) -> 7 -> 0.
  - Durations: 0/4 GREEN_TICKS; 1/5 YELLOW_TICKS; 2/6 ALLRED_TICKS; 3/7 LEFT_TICKS.
- Left latches:
  - left_req[i] high in any cycle sets latch i.
  - Latch i clears on entry to its left phase (EW=3, NS=7).
  - Set and clear in the same cycle: set wins, so demand arriving during entry is served next cycle.
- Emergency:
  - emergency is registered once internally; emergency_active mirrors the registered value OR an all-red hold in progress.
  - On the first tick with registered emergency=1:
    - from 0 go to 1 and from 4 go to 5, regardless of timer value;
    - from 3 go to 6 and from 7 go to 2 (arrow drops straight to all-red).
  - Yellow phases 1/5 always run to full duration.
  - In 2/6, while emergency=1: timer is held at ALLRED_TICKS-1 and no transition occurs.
  - After emergency deasserts: full ALLRED_TICKS clearance, then the normal successor. From 2 the normal successor is 3 or 4; from 6 it is 7 or 0.
  - emergency_active drops on the edge the sequencer leaves all-red.
  - Emergency arriving mid-yellow: yellow completes, then hold.
  - Emergency deasserting before preemption takes effect: no deviation from the normal sequence.
- Simultaneous events:
  - Emergency takes priority over left-turn service; latches are retained, not cleared.
  - Timer reaching 0 and emergency on the same tick: emergency transition applies.
- Illegal states (unreachable): phase forced to 6 with timer reloaded.
- phase_start is 1 in the first cycle after reset release.

Decomposition:
- Shared package intersection_pkg:
  - phase codes PH_NS_GREEN=0 .. PH_NS_LEFT=7;
  - road index constants NS=0, EW=1.
  - led_control later switches to these codes.
- One sub-module, tick_prescaler: parameter TICK_DIV; ports CLOCK_50, reset, tick. It supersedes counter1/counter2.
- FSM, timer and latches stay in phase_sequencer.

Test Plan:
Bench parameters: TICK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, LEFT=2.
1. Reset, then no requests, 80 cycles -> phase sequence 6,0,1,2,4,5,6,0; dwell in 0 = 12 cycles; phase_start pulses once per change; tick period 4.
2. Pulse left_req=10 one cycle during phase 0 -> 3 occurs after 2 for 8 cycles; a second pass of 2 goes straight to 4.
3. Pulse left_req=01 during 4; also pulse left_req=01 on the cycle 7 is entered -> 7 served twice in consecutive cycles of the sequence.
4. Assert emergency mid-phase 0 with timer=2 -> next tick goes to 1, then 2, holding with ticks_left=0. Deassert -> one tick later goes to 3 or 4; emergency_active high from registration to exit from 2.
5. Assert emergency during 3 -> next tick goes to 6, holds. Assert it during phase 5 -> yellow completes its 2 ticks, then 6.
6. Assert reset asynchronously mid-phase 4 between clock edges -> phase=6, ticks_left=0, latches=00 immediately. Deassert -> normal restart at 0.
